// File: rtl/pipe_ctrl_unit_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, control encodings and bus bit positions
package mips_ctrl_pkg;
   localparam int NB_OPCODE_D  = 6;
   localparam int NB_FUNCT_D   = 6;
   localparam int NB_REG_D     = 5;
   localparam int NB_CTRL_WB_D = 2;
   localparam int NB_CTRL_M_D  = 8;
   localparam int NB_CTRL_EX_D = 11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [3:0] ALU_RTYPE = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_LUI   = 4'b0101;
   localparam logic [3:0] ALU_SLT   = 4'b0110;
   localparam logic [3:0] ALU_SLTU  = 4'b0111;
   localparam logic [3:0] ALU_SUB   = 4'b1000;

   localparam logic [1:0] SRC_REG  = 2'b00;
   localparam logic [1:0] SRC_SEXT = 2'b01;
   localparam logic [1:0] SRC_ZEXT = 2'b10;
   localparam logic [1:0] SRC_PC8  = 2'b11;

   localparam logic [1:0] WB_ALU  = 2'b10;
   localparam logic [1:0] WB_LOAD = 2'b11;

   localparam int M_SB       = 7;
   localparam int M_SH       = 6;
   localparam int M_LB       = 5;
   localparam int M_LH       = 4;
   localparam int M_UNSIGNED = 3;
   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   function automatic logic [10:0] pack_ex(logic link, logic reg_dst, logic [1:0] src,
                                           logic jump, logic jump_reg, logic bne, logic [3:0] alu);
      return {link, reg_dst, src, jump, jump_reg, bne, alu};
   endfunction
endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: IF/ID-side inputs and ID/EX-side control outputs of the control unit
interface pipe_ctrl_unit_if
   import mips_ctrl_pkg::*;
#(
   parameter int NB_OPCODE  = NB_OPCODE_D,
   parameter int NB_FUNCT   = NB_FUNCT_D,
   parameter int NB_REG     = NB_REG_D,
   parameter int NB_CTRL_WB = NB_CTRL_WB_D,
   parameter int NB_CTRL_M  = NB_CTRL_M_D,
   parameter int NB_CTRL_EX = NB_CTRL_EX_D
);
   logic                  i_valid;
   logic [NB_OPCODE-1:0]  i_opcode;
   logic [NB_FUNCT-1:0]   i_funct;
   logic [NB_REG-1:0]     i_rs;
   logic [NB_REG-1:0]     i_rt;
   logic [NB_REG-1:0]     i_rd;
   logic                  i_flush;
   logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus;
   logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus;
   logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus;
   logic [NB_REG-1:0]     o_ex_dst;
   logic                  o_ex_valid;
   logic                  o_stall;
   logic                  o_illegal;

   modport master (
      output i_valid, i_opcode, i_funct, i_rs, i_rt, i_rd, i_flush,
      input  o_ctrl_wb_bus, o_ctrl_mem_bus, o_ctrl_exc_bus, o_ex_dst, o_ex_valid, o_stall, o_illegal
   );
   modport slave (
      input  i_valid, i_opcode, i_funct, i_rs, i_rt, i_rd, i_flush,
      output o_ctrl_wb_bus, o_ctrl_mem_bus, o_ctrl_exc_bus, o_ex_dst, o_ex_valid, o_stall, o_illegal
   );
endinterface

// File: rtl/pipe_ctrl_unit_decoder.sv
// ctrl_decoder: combinational opcode/funct decode into WB/MEM/EX buses, destination and source use
module ctrl_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int NB_OPCODE  = NB_OPCODE_D,
   parameter int NB_FUNCT   = NB_FUNCT_D,
   parameter int NB_REG     = NB_REG_D,
   parameter int NB_CTRL_WB = NB_CTRL_WB_D,
   parameter int NB_CTRL_M  = NB_CTRL_M_D,
   parameter int NB_CTRL_EX = NB_CTRL_EX_D
) (
   input  logic [NB_OPCODE-1:0]  i_opcode,
   input  logic [NB_FUNCT-1:0]   i_funct,
   input  logic [NB_REG-1:0]     i_rt,
   input  logic [NB_REG-1:0]     i_rd,
   output logic [NB_CTRL_WB-1:0] o_wb,
   output logic [NB_CTRL_M-1:0]  o_mem,
   output logic [NB_CTRL_EX-1:0] o_ex,
   output logic [NB_REG-1:0]     o_dst,
   output logic                  o_uses_rs,
   output logic                  o_uses_rt,
   output logic                  o_illegal
);
   always_comb begin
      o_wb      = '0;
      o_mem     = '0;
      o_ex      = '0;
      o_uses_rs = 1'b1;
      o_uses_rt = 1'b0;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            o_uses_rt = 1'b1;
            case (i_funct)
               FN_JR:   o_ex = pack_ex(1'b0, 1'b0, SRC_REG, 1'b0, 1'b1, 1'b0, ALU_RTYPE);
               FN_JALR: begin
                  o_wb = WB_ALU;
                  o_ex = pack_ex(1'b1, 1'b1, SRC_PC8, 1'b0, 1'b1, 1'b0, ALU_RTYPE);
               end
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB,
               FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                  o_wb = WB_ALU;
                  o_ex = pack_ex(1'b0, 1'b1, SRC_REG, 1'b0, 1'b0, 1'b0, ALU_RTYPE);
               end
               default: o_illegal = 1'b1;
            endcase
         end
         OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
            o_wb                = WB_LOAD;
            o_mem[M_MEMREAD]    = 1'b1;
            o_mem[M_LH]         = i_opcode == OP_LH || i_opcode == OP_LHU;
            o_mem[M_LB]         = i_opcode == OP_LB || i_opcode == OP_LBU;
            o_mem[M_UNSIGNED]   = i_opcode == OP_LHU || i_opcode == OP_LBU;
            o_ex                = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_ADD);
         end
         OP_SW, OP_SH, OP_SB: begin
            o_uses_rt         = 1'b1;
            o_mem[M_MEMWRITE] = 1'b1;
            o_mem[M_SH]       = i_opcode == OP_SH;
            o_mem[M_SB]       = i_opcode == OP_SB;
            o_ex              = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_ADD);
         end
         OP_BEQ, OP_BNE: begin
            o_uses_rt       = 1'b1;
            o_mem[M_BRANCH] = 1'b1;
            o_ex            = pack_ex(1'b0, 1'b0, SRC_REG, 1'b0, 1'b0, i_opcode == OP_BNE, ALU_SUB);
         end
         OP_ADDI, OP_ADDIU: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_ADD);
         end
         OP_SLTI: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_SLT);
         end
         OP_SLTIU: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_SLTU);
         end
         OP_ANDI: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_ZEXT, 1'b0, 1'b0, 1'b0, ALU_AND);
         end
         OP_ORI: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_ZEXT, 1'b0, 1'b0, 1'b0, ALU_OR);
         end
         OP_XORI: begin
            o_wb = WB_ALU;
            o_ex = pack_ex(1'b0, 1'b0, SRC_ZEXT, 1'b0, 1'b0, 1'b0, ALU_XOR);
         end
         OP_LUI: begin
            o_uses_rs = 1'b0;
            o_wb      = WB_ALU;
            o_ex      = pack_ex(1'b0, 1'b0, SRC_SEXT, 1'b0, 1'b0, 1'b0, ALU_LUI);
         end
         OP_J: begin
            o_uses_rs = 1'b0;
            o_ex      = pack_ex(1'b0, 1'b0, SRC_REG, 1'b1, 1'b0, 1'b0, ALU_RTYPE);
         end
         OP_JAL: begin
            o_uses_rs = 1'b0;
            o_wb      = WB_ALU;
            o_ex      = pack_ex(1'b1, 1'b0, SRC_PC8, 1'b1, 1'b0, 1'b0, ALU_ADD);
         end
         default: o_illegal = 1'b1;
      endcase
      o_dst = o_ex[9] ? i_rd : (i_opcode == OP_JAL) ? {NB_REG{1'b1}} : i_rt;
   end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage control decode, load-use stall counter and ID/EX control register
module pipe_ctrl_unit
   import mips_ctrl_pkg::*;
#(
   parameter int NB_OPCODE       = NB_OPCODE_D,
   parameter int NB_FUNCT        = NB_FUNCT_D,
   parameter int NB_REG          = NB_REG_D,
   parameter int NB_CTRL_WB      = NB_CTRL_WB_D,
   parameter int NB_CTRL_M       = NB_CTRL_M_D,
   parameter int NB_CTRL_EX      = NB_CTRL_EX_D,
   parameter int LOAD_USE_STALLS = 1
) (
   input logic             i_clk,
   input logic             i_rst,
   pipe_ctrl_unit_if.slave bus
);
   logic [NB_CTRL_WB-1:0] dec_wb, wb_q;
   logic [NB_CTRL_M-1:0]  dec_mem, mem_q;
   logic [NB_CTRL_EX-1:0] dec_ex, ex_q;
   logic [NB_REG-1:0]     dec_dst, dst_q;
   logic                  dec_rs, dec_rt, dec_ill, valid_q, ill_q;
   logic [2:0]            cnt;
   logic                  hazard, stall, bubble;

   ctrl_decoder #(
      .NB_OPCODE(NB_OPCODE), .NB_FUNCT(NB_FUNCT), .NB_REG(NB_REG),
      .NB_CTRL_WB(NB_CTRL_WB), .NB_CTRL_M(NB_CTRL_M), .NB_CTRL_EX(NB_CTRL_EX)
   ) u_dec (
      .i_opcode(bus.i_opcode), .i_funct(bus.i_funct), .i_rt(bus.i_rt), .i_rd(bus.i_rd),
      .o_wb(dec_wb), .o_mem(dec_mem), .o_ex(dec_ex), .o_dst(dec_dst),
      .o_uses_rs(dec_rs), .o_uses_rt(dec_rt), .o_illegal(dec_ill)
   );

   assign hazard = valid_q & mem_q[M_MEMREAD] & bus.i_valid & ~dec_ill & (dst_q != '0) &
                   ((dec_rs & (bus.i_rs == dst_q)) | (dec_rt & (bus.i_rt == dst_q)));
   // a taken branch/jump squashes ID, so it overrides any pending stall
   assign stall  = ~bus.i_flush & (hazard | (cnt != 3'd0));
   assign bubble = stall | bus.i_flush | ~bus.i_valid | dec_ill;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt     <= '0;
         wb_q    <= '0;
         mem_q   <= '0;
         ex_q    <= '0;
         dst_q   <= '0;
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         cnt     <= bus.i_flush ? 3'd0 : (cnt != 3'd0) ? cnt - 3'd1 :
                    hazard ? 3'(LOAD_USE_STALLS - 1) : 3'd0;
         wb_q    <= bubble ? '0 : dec_wb;
         mem_q   <= bubble ? '0 : dec_mem;
         ex_q    <= bubble ? '0 : dec_ex;
         dst_q   <= bubble ? '0 : dec_dst;
         valid_q <= ~bubble;
         ill_q   <= bus.i_valid & dec_ill & ~bus.i_flush & ~stall;
      end
   end

   assign bus.o_ctrl_wb_bus  = wb_q;
   assign bus.o_ctrl_mem_bus = mem_q;
   assign bus.o_ctrl_exc_bus = ex_q;
   assign bus.o_ex_dst       = dst_q;
   assign bus.o_ex_valid     = valid_q;
   assign bus.o_illegal      = ill_q;
   assign bus.o_stall        = stall;
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined MIPS control unit with a parametrised ID/EX control register and load-use hazard handling. It decodes the instruction in ID into WB, MEM and EX control buses, then registers them into the ID/EX stage. It also detects load-use hazards against the instruction already in EX, stalls IF/ID and injects bubbles, and squashes on flush or illegal opcodes. It sits between the IF/ID pipeline register and the datapath's ID/EX register, and supersedes the purely combinational opcode decoder.

## Interface
Parameters:
- NB_OPCODE, 6, opcode width
- NB_FUNCT, 6, funct width
- NB_REG, 5, register-index width
- NB_CTRL_WB, 2, WB bus width
- NB_CTRL_M, 8, MEM bus width
- NB_CTRL_EX, 11, EX bus width
- LOAD_USE_STALLS, 1, bubble cycles per load-use hazard (1..7)

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_opcode  in  NB_OPCODE  instruction[31:26]
- i_funct  in  NB_FUNCT  instruction[5:0]
- i_rs, i_rt, i_rd  in  NB_REG each  instruction register fields
- i_flush  in  1  branch/jump resolved taken; squash ID
- o_ctrl_wb_bus  out  NB_CTRL_WB  registered: [1] RegWrite, [0] MemtoReg
- o_ctrl_mem_bus  out  NB_CTRL_M  registered: [7] SB, [6] SH, [5] LB, [4] LH, [3] Unsigned, [2] Branch, [1] MemRead, [0] MemWrite
- o_ctrl_exc_bus  out  NB_CTRL_EX  registered: [10] Link, [9] RegDst, [8:7] ALUSrc, [6] Jump, [5] JumpReg, [4] BranchNE, [3:0] ALUCode
- o_ex_dst  out  NB_REG  registered destination register (31 for JAL)
- o_ex_valid  out  1  ID/EX holds a real instruction
- o_stall  out  1  combinational; hold PC and IF/ID
- o_illegal  out  1  registered one-cycle pulse on an unknown opcode or funct

## Operation
- Decode covers:
  - R-type, including JR (JumpReg) and JALR (JumpReg and Link).
  - Loads LW, LH, LHU, LB, LBU and stores SW, SH, SB.
  - Branches BEQ, BNE (BranchNE=1).
  - Immediates ADDI, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU.
  - Jumps J and JAL.
  - Unsigned=1 for LHU and LBU.
- ALUSrc encoding: 00 = register, 01 = sign-extended immediate, 10 = zero-extended immediate (ANDI, ORI, XORI), 11 = PC+8 (JAL, JALR).
- ALUCode encoding: 0000 R-type (use funct), 0001 ADD, 0010 AND, 0011 OR, 0100 XOR, 0101 LUI, 0110 SLT, 0111 SLTU, 1000 SUB (branches).
- Destination register: rd if RegDst, 31 if JAL, else rt.
- Source-use rules:
  - uses_rs: every instruction except J, JAL and LUI.
  - uses_rt: R-type, BEQ, BNE and stores.
- Hazard condition: `o_ex_valid & MemRead(EX) & i_valid & ((uses_rs & i_rs==o_ex_dst) | (uses_rt & i_rt==o_ex_dst)) & o_ex_dst!=0`.
- Stall counter cnt, 3 bits:
  - On a hazard with cnt==0, cnt loads LOAD_USE_STALLS-1.
  - While cnt!=0 it decrements by one each cycle.
  - o_stall = hazard | (cnt!=0).
- Bubble insertion: the ID/EX register loads all-zero buses and o_ex_valid=0 on any of:
  - o_stall
  - i_flush
  - !i_valid
  - illegal decode
- Otherwise the ID/EX register loads the decoded buses with o_ex_valid=1.
- Flush priority:
  - i_flush outranks stall: cnt clears to 0 and o_stall is forced 0 that cycle.
  - Illegal decode does not raise a hazard.

## Timing
- Decode to ID/EX outputs: one cycle of latency.
- o_stall: same cycle as the hazard, with no register in the path.
- LOAD_USE_STALLS=N: exactly N bubbles are issued, then the held instruction issues on the (N+1)th edge.
- Reset, asynchronous assertion, including mid-stall: every bus 0, o_ex_dst 0, o_ex_valid 0, o_illegal 0, cnt 0, so o_stall 0.
- Reset deassertion: takes effect at the next rising clock edge.
- o_illegal: high for exactly one cycle, aligned with the bubble it caused.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - ALUCode and ALUSrc encodings
  - bus bit-index localparams
- Sub-module ctrl_decoder: pure combinational decode of opcode/funct to buses, dst, uses_rs, uses_rt and illegal.
- Top level holds:
  - the hazard compare
  - the stall counter
  - the flush/bubble mux
  - the ID/EX registers

## Test plan
- Reset, then LW (100011) with rt=5 and i_valid=1 → next cycle: wb=2'b11, mem=8'b00000010, ALUSrc=01, o_ex_dst=5, o_ex_valid=1.
- LW $5 then ADD with rs=5, LOAD_USE_STALLS=1 → o_stall=1 for one cycle, one bubble (buses 0, o_ex_valid=0), then ADD issues with wb=2'b10 and RegDst=1.
- Same sequence with LOAD_USE_STALLS=3 → o_stall high for 3 cycles, 3 bubbles; with i_flush in the 2nd stall cycle → o_stall drops the same cycle, cnt=0, a bubble follows.
- JAL (000011) → exc Link=1, Jump=1, ALUSrc=11, o_ex_dst=31, RegWrite=1; no stall even if EX is a load to $31.
- Opcode 111111 → bubble, o_illegal pulse for 1 cycle; LW to $0 followed by a use of $0 → no stall.
- Assert i_rst low mid-stall (cnt=2) → all outputs 0 immediately, before any clock edge.
